// File: rtl/async_init_shift_reg_if.sv
// Bus bundle for async_init_shift_reg: shift controls and data in, tail stage and status out.
// No backpressure: d/d_valid are sampled on every rising edge where en=1 and flush=0.
interface async_init_shift_reg_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             primed;

    modport master (
        output en, flush, d, d_valid,
        input  q, q_valid, primed
    );

    modport slave (
        input  en, flush, d, d_valid,
        output q, q_valid, primed
    );
endinterface

// File: rtl/async_init_shift_reg.sv
// Multi-stage, multi-bit register pipeline with async per-bit init value, per-stage valid,
// synchronous flush and a "primed" flag once the pipeline holds only post-reset data.
module async_init_shift_reg #(
    parameter int               WIDTH = 1,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input logic                    clk,
    input logic                    rst,
    async_init_shift_reg_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] s [DEPTH];
    logic [DEPTH-1:0] v;
    logic [CW-1:0]    cnt;
    logic             primed_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) s[i] <= INIT;
            v        <= '0;
            cnt      <= '0;
            primed_r <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) s[i] <= INIT;
            v        <= '0;
            cnt      <= '0;
            primed_r <= 1'b0;
        end else if (bus.en) begin
            s[0] <= bus.d;
            v[0] <= bus.d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                s[i] <= s[i-1];
                v[i] <= v[i-1];
            end
            if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
            // primed is registered separately so the output never passes through a comparator
            if (cnt == CW'(DEPTH - 1)) primed_r <= 1'b1;
        end
    end

    assign bus.q       = s[DEPTH-1];
    assign bus.q_valid = v[DEPTH-1];
    assign bus.primed  = primed_r;
endmodule

// File: tb/tb_async_init_shift_reg.sv
// Bench for async_init_shift_reg: three configurations driven from one clock,
// expected {primed, q_valid, q} words queued at drive time and popped after each edge.
module tb_async_init_shift_reg;
    logic clk;
    logic clk_run;
    logic rst_a, rst_b, rst_c;

    async_init_shift_reg_if #(.WIDTH(4)) bus_a ();
    async_init_shift_reg_if #(.WIDTH(8)) bus_b ();
    async_init_shift_reg_if #(.WIDTH(2)) bus_c ();

    async_init_shift_reg #(.WIDTH(4), .DEPTH(3), .INIT(4'hA)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a)
    );
    async_init_shift_reg #(.WIDTH(8), .DEPTH(1), .INIT(8'hC3)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b)
    );
    async_init_shift_reg #(.WIDTH(2), .DEPTH(4)) dut_c (
        .clk(clk), .rst(rst_c), .bus(bus_c)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, got, 32'hDEAD_BEEF);
        else check(tag, got, exp_q.pop_front());
    endtask

    function automatic logic [31:0] obs_a();
        return 32'({bus_a.primed, bus_a.q_valid, bus_a.q});
    endfunction
    function automatic logic [31:0] obs_b();
        return 32'({bus_b.primed, bus_b.q_valid, bus_b.q});
    endfunction
    function automatic logic [31:0] obs_c();
        return 32'({bus_c.primed, bus_c.q_valid, bus_c.q});
    endfunction

    // drivers: inputs set away from the edge, outputs sampled 1 time unit after it
    task automatic step_a(input string tag, input logic en, input logic fl, input logic [3:0] d,
                          input logic dv, input logic ep, input logic ev, input logic [3:0] eq);
        bus_a.en = en; bus_a.flush = fl; bus_a.d = d; bus_a.d_valid = dv;
        exp_q.push_back(32'({ep, ev, eq}));
        @(posedge clk); #1;
        sb_check(tag, obs_a());
    endtask

    task automatic step_b(input string tag, input logic en, input logic [7:0] d,
                          input logic ep, input logic ev, input logic [7:0] eq);
        bus_b.en = en; bus_b.flush = 1'b0; bus_b.d = d; bus_b.d_valid = 1'b1;
        exp_q.push_back(32'({ep, ev, eq}));
        @(posedge clk); #1;
        sb_check(tag, obs_b());
    endtask

    task automatic step_c(input string tag, input logic en, input logic fl, input logic [1:0] d,
                          input logic dv, input logic ep, input logic ev, input logic [1:0] eq);
        bus_c.en = en; bus_c.flush = fl; bus_c.d = d; bus_c.d_valid = dv;
        exp_q.push_back(32'({ep, ev, eq}));
        @(posedge clk); #1;
        sb_check(tag, obs_c());
    endtask

    // reference history for the randomised DEPTH=4 run
    logic [1:0] m_s [4];
    logic       m_v [4];
    int         m_cnt;

    initial begin
        clk_run = 1'b0;
        {rst_a, rst_b, rst_c} = 3'b111;
        bus_a.en = 0; bus_a.flush = 0; bus_a.d = '0; bus_a.d_valid = 0;
        bus_b.en = 0; bus_b.flush = 0; bus_b.d = '0; bus_b.d_valid = 0;
        bus_c.en = 0; bus_c.flush = 0; bus_c.d = '0; bus_c.d_valid = 0;

        // reset with no clock running
        #1;
        check("rst_a", obs_a(), 32'({1'b0, 1'b0, 4'hA}));
        check("rst_b", obs_b(), 32'({1'b0, 1'b0, 8'hC3}));
        check("rst_c", obs_c(), 32'({1'b0, 1'b0, 2'h0}));
        #4;
        {rst_a, rst_b, rst_c} = 3'b000;
        #4;
        clk_run = 1'b1;
        @(posedge clk); #1;

        // A: fill with 1,2,3
        step_a("a_fill1", 1, 0, 4'h1, 1, 0, 0, 4'hA);
        step_a("a_fill2", 1, 0, 4'h2, 1, 0, 0, 4'hA);
        step_a("a_fill3", 1, 0, 4'h3, 1, 1, 1, 4'h1);
        // A: hold with en=0 for 5 cycles, d undriven
        for (int i = 0; i < 5; i++) step_a("a_hold", 0, 0, 4'hx, 1'bx, 1, 1, 4'h1);
        step_a("a_shift4", 1, 0, 4'h4, 1, 1, 1, 4'h2);
        // A: flush beats en
        step_a("a_flush", 1, 1, 4'hF, 1, 0, 0, 4'hA);
        step_a("a_post_fl1", 1, 0, 4'h5, 1, 0, 0, 4'hA);
        step_a("a_post_fl2", 1, 0, 4'h6, 1, 0, 0, 4'hA);
        step_a("a_post_fl3", 1, 0, 4'h7, 1, 1, 1, 4'h5);
        bus_a.en = 0;

        // B: DEPTH=1, async reset between edges
        step_b("b_load", 1, 8'h55, 1, 1, 8'h55);
        #2 rst_b = 1'b1;
        #1 check("b_async_rst", obs_b(), 32'({1'b0, 1'b0, 8'hC3}));
        step_b("b_rst_held", 1, 8'hAA, 0, 0, 8'hC3);
        #3 rst_b = 1'b0;
        step_b("b_reload", 1, 8'h3C, 1, 1, 8'h3C);
        step_b("b_hold", 0, 8'hxx, 1, 1, 8'h3C);

        // C: valid pattern 1,0,1,1
        step_c("c_e1", 1, 0, 2'h1, 1, 0, 0, 2'h0);
        step_c("c_e2", 1, 0, 2'h2, 0, 0, 0, 2'h0);
        step_c("c_e3", 1, 0, 2'h3, 1, 0, 0, 2'h0);
        step_c("c_e4", 1, 0, 2'h0, 1, 1, 1, 2'h1);
        step_c("c_e5", 1, 0, 2'h0, 0, 1, 0, 2'h2);
        step_c("c_e6", 1, 0, 2'h0, 0, 1, 1, 2'h3);
        step_c("c_e7", 1, 0, 2'h0, 0, 1, 1, 2'h0);

        // C: randomised run against the history model, starting from a flush
        step_c("c_flush", 0, 1, 2'h3, 1, 0, 0, 2'h0);
        for (int i = 0; i < 4; i++) begin m_s[i] = 2'h0; m_v[i] = 1'b0; end
        m_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            logic en, fl, dv;
            logic [1:0] d;
            en = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 11) == 0);
            d  = 2'($urandom_range(0, 3));
            dv = 1'($urandom_range(0, 1));
            if (fl) begin
                for (int i = 0; i < 4; i++) begin m_s[i] = 2'h0; m_v[i] = 1'b0; end
                m_cnt = 0;
            end else if (en) begin
                for (int i = 3; i > 0; i--) begin m_s[i] = m_s[i-1]; m_v[i] = m_v[i-1]; end
                m_s[0] = d; m_v[0] = dv;
                if (m_cnt < 4) m_cnt++;
            end
            step_c("c_rand", en, fl, d, dv, (m_cnt == 4), m_v[3], m_s[3]);
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // overall time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
